// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button input path.
package button_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } debounce_state_t;

  // Channel count shared with the downstream button peripheral.
  localparam int unsigned N_BUTTONS_DEFAULT = 4;

  // Default number of stable synchronised cycles before a level is accepted.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/button_debounce_channel.sv
// One button line: 2-flop synchroniser, counter-based debounce FSM,
// registered clean level and one-cycle press/release pulses.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_state,
  output logic button_pressed,
  output logic button_released
);

  localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit                 SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic            sync1_q;
  logic            sync2_q;
  debounce_state_t fsm_q,   fsm_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic            level_q, level_d;
  logic            rise_q,  rise_d;
  logic            fall_q,  fall_d;

  // Bring the asynchronous raw level into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state, counter, clean level and event pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic: any return to the old level restarts the count; the
  // level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (fsm_q)
      IDLE_LO: begin
        if (sync2_q) begin
          if (SINGLE) begin
            fsm_d   = IDLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            fsm_d = WAIT_HI;
            cnt_d = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          fsm_d = IDLE_LO;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d   = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          if (SINGLE) begin
            fsm_d   = IDLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            fsm_d = WAIT_LO;
            cnt_d = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          fsm_d = IDLE_HI;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          fsm_d   = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        fsm_d   = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign button_state    = level_q;
  assign button_pressed  = rise_q;
  assign button_released = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// N independent debounced button channels for the button peripheral.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = N_BUTTONS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] button_raw,
  output logic [N_BUTTONS-1:0] button_state,
  output logic [N_BUTTONS-1:0] button_pressed,
  output logic [N_BUTTONS-1:0] button_released
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .button_raw     (button_raw[i]),
      .button_state   (button_state[i]),
      .button_pressed (button_pressed[i]),
      .button_released(button_released[i])
    );
  end

endmodule
